// File: rtl/fp_add_normalizer_if.sv
// Handshake and data bundle between the mantissa adder, the normalizer and its consumer.
// The slave modport is the normalizer; the master modport is the stage driving it.
interface fp_add_normalizer_if #(
   parameter int unsigned MANT_W  = 25,
   parameter int unsigned EXP_W   = 8,
   parameter int unsigned SHCNT_W = 5
);
   localparam int unsigned RES_W = 1 + EXP_W + MANT_W - 2;

   logic               in_valid;
   logic               in_ready;
   logic               sign_in;
   logic [EXP_W-1:0]   exp_in;
   logic [MANT_W-1:0]  sum_in;
   logic               out_valid;
   logic               out_ready;
   logic [RES_W-1:0]   result;
   logic               overflow;
   logic               underflow;
   logic               zero;
   logic [SHCNT_W-1:0] norm_shift;

   modport master (
      output in_valid, sign_in, exp_in, sum_in, out_ready,
      input  in_ready, out_valid, result, overflow, underflow, zero, norm_shift
   );

   modport slave (
      input  in_valid, sign_in, exp_in, sum_in, out_ready,
      output in_ready, out_valid, result, overflow, underflow, zero, norm_shift
   );
endinterface

// File: rtl/fp_add_normalizer.sv
// Post-adder normalizer: shifts the mantissa sum left one bit per cycle, adjusts the
// exponent, flags overflow/underflow/zero and packs a single-precision word (truncating).
module fp_add_normalizer #(
   parameter int unsigned MANT_W  = 25,
   parameter int unsigned EXP_W   = 8,
   parameter int unsigned SHCNT_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   fp_add_normalizer_if.slave  bus
);
   localparam int unsigned FRAC_W = MANT_W - 2;
   localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;
   localparam logic [EXP_W:0] EXP_SAT = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0] EXP_ONE = (EXP_W + 1)'(1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic               sign_q, sign_d;
   logic [EXP_W:0]     exp_q, exp_d;
   logic [MANT_W-1:0]  mant_q, mant_d;
   logic [SHCNT_W-1:0] shcnt_q, shcnt_d;
   logic [RES_W-1:0]   result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               zero_q, zero_d;

   logic              sum_zero, sum_carry, exp_zero;
   logic [EXP_W:0]    exp_inc;
   logic [MANT_W-1:0] sum_shr;
   logic              mant_norm, exp_floor;

   assign sum_zero  = (bus.sum_in == '0);
   assign sum_carry = bus.sum_in[MANT_W-1];
   assign exp_zero  = (bus.exp_in == '0);
   assign exp_inc   = {1'b0, bus.exp_in} + EXP_ONE;
   assign sum_shr   = bus.sum_in >> 1;
   assign mant_norm = mant_q[FRAC_W];
   assign exp_floor = (exp_q == EXP_ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         shcnt_q  <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         shcnt_q  <= shcnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               state_d = (sum_zero || sum_carry || exp_zero) ? StDone : StShift;
            end
         end
         StShift: begin
            if (mant_norm || exp_floor) state_d = StDone;
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next state; the result word and flags are only written on the way into DONE.
   always_comb begin
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      shcnt_d  = shcnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      zero_d   = zero_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               sign_d  = bus.sign_in;
               exp_d   = {1'b0, bus.exp_in};
               mant_d  = bus.sum_in;
               shcnt_d = '0;
               if (sum_zero) begin
                  result_d = '0;
                  zero_d   = 1'b1;
               end else if (sum_carry) begin
                  mant_d = sum_shr;
                  exp_d  = exp_inc;
                  if (exp_inc >= EXP_SAT) begin
                     result_d = {bus.sign_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                     ovf_d    = 1'b1;
                  end else begin
                     result_d = {bus.sign_in, exp_inc[EXP_W-1:0], sum_shr[FRAC_W-1:0]};
                  end
               end else if (exp_zero) begin
                  result_d = {bus.sign_in, {(RES_W-1){1'b0}}};
                  unf_d    = 1'b1;
               end
            end
         end
         StShift: begin
            if (mant_norm) begin
               result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
            end else if (exp_floor) begin
               result_d = {sign_q, {(RES_W-1){1'b0}}};
               unf_d    = 1'b1;
            end else begin
               mant_d  = mant_q << 1;
               exp_d   = exp_q - EXP_ONE;
               shcnt_d = shcnt_q + SHCNT_W'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               result_d = '0;
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               zero_d   = 1'b0;
               shcnt_d  = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.in_ready   = (state_q == StIdle);
      bus.out_valid  = (state_q == StDone);
      bus.result     = result_q;
      bus.overflow   = ovf_q;
      bus.underflow  = unf_q;
      bus.zero       = zero_q;
      bus.norm_shift = shcnt_q;
   end
endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed and randomized bench for fp_add_normalizer against an arithmetic reference model.
module tb_fp_add_normalizer;
   logic clk;
   logic rst;
   int   n_vec  = 0;
   int   n_fail = 0;

   fp_add_normalizer_if bus ();

   fp_add_normalizer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: count leading zeros arithmetically, then decide pack vs. flush by exponent.
   task automatic model(input logic s, input int e, input int m, output logic [31:0] r,
                        output logic [2:0] fl, output int sh, output int lat);
      int lz;
      sh = 0;
      fl = 3'b000;
      if (m == 0) begin
         r = 32'h0; fl = 3'b001; lat = 1;
      end else if (m >= (1 << 24)) begin
         lat = 1;
         if (e + 1 >= 255) begin
            r = {s, 8'hFF, 23'h0}; fl = 3'b100;
         end else begin
            r = {s, 8'(e + 1), 23'(m / 2)};
         end
      end else if (e == 0) begin
         r = {s, 31'h0}; fl = 3'b010; lat = 1;
      end else begin
         lz = 0;
         while ((m << lz) < (1 << 23)) lz++;
         if (e - lz >= 1) begin
            sh = lz;
            r  = {s, 8'(e - lz), 23'(m << lz)};
         end else begin
            sh = e - 1;
            r  = {s, 31'h0}; fl = 3'b010;
         end
         lat = sh + 2;
      end
   endtask

   task automatic accept_op(input logic s, input logic [7:0] e, input logic [24:0] m);
      @(negedge clk);
      bus.sign_in  = s;
      bus.exp_in   = e;
      bus.sum_in   = m;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input int hold, output logic [31:0] got);
      logic [31:0] er;
      logic [2:0]  ef;
      int          es, el, lat;
      model(s, int'(e), int'(m), er, ef, es, el);
      accept_op(s, e, m);
      wait_done(lat);
      chk("latency", 32'(lat), 32'(el));
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("result", bus.result, er);
      chk("flags", 32'({bus.overflow, bus.underflow, bus.zero}), 32'(ef));
      chk("norm_shift", 32'(bus.norm_shift), 32'(es));
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      got = bus.result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.sum_in   = 25'($urandom);
         bus.exp_in   = 8'($urandom);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_result", bus.result, er);
         chk("hold_flags", 32'({bus.overflow, bus.underflow, bus.zero}), 32'(ef));
         chk("hold_shift", 32'(bus.norm_shift), 32'(es));
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      // in_valid held across the transfer edge must not be taken on that edge
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("xfer_valid", 32'(bus.out_valid), 32'd0);
      chk("xfer_in_ready", 32'(bus.in_ready), 32'd1);
      chk("xfer_flags", 32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic [24:0] m;
      logic [7:0]  e;
      int          k;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.sign_in   = 1'b0;
      bus.exp_in    = '0;
      bus.sum_in    = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
      chk("rst_norm_shift", 32'(bus.norm_shift), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      do_op(1'b0, 8'h7F, 25'h0800000, 0, got);
      chk("plan_normalized", got, 32'h3F800000);
      do_op(1'b0, 8'h7F, 25'h1000000, 0, got);
      chk("plan_carry", got, 32'h40000000);
      do_op(1'b0, 8'hFE, 25'h1000000, 0, got);
      chk("plan_overflow", got, 32'h7F800000);
      do_op(1'b0, 8'h7F, 25'h0000001, 1, got);
      chk("plan_max_shift", got, 32'h34000000);
      do_op(1'b1, 8'h05, 25'h0000100, 0, got);
      chk("plan_underflow", got, 32'h80000000);
      do_op(1'b1, 8'h00, 25'h0000000, 5, got);
      chk("plan_zero", got, 32'h00000000);
      do_op(1'b1, 8'h00, 25'h0400000, 0, got);
      chk("exp_zero_flush", got, 32'h80000000);

      // Asynchronous reset while normalizing a long shift
      accept_op(1'b0, 8'h7F, 25'h0000001);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_result", bus.result, 32'h0);
      chk("rst_mid_shift", 32'(bus.norm_shift), 32'd0);
      chk("rst_mid_flags", 32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      do_op(1'b0, 8'h7F, 25'h0800000, 0, got);
      chk("post_rst_op", got, 32'h3F800000);

      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 23);
         case ($urandom_range(0, 3))
            0:       m = 25'h0;
            1:       m = 25'h1000000 | 25'($urandom & 32'hFFFFFF);
            default: m = 25'((32'd1 << k) | ($urandom & ((32'd1 << k) - 32'd1)));
         endcase
         case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'd1;
            2:       e = 8'd254;
            3:       e = 8'd255;
            4:       e = 8'($urandom_range(2, 30));
            default: e = 8'($urandom_range(0, 255));
         endcase
         do_op(1'($urandom), e, m, $urandom_range(0, 3), got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_add_normalizer.md
Name: fp_add_normalizer

Overview:
- Post-adder normalization stage of the single-precision floating-point adder.
- Consumes the 25-bit signed-magnitude mantissa sum (bit 24 = carry-out, bit 23 = hidden-bit position) from the mantissa adder/subtractor, together with the tentative exponent and result sign.
- Normalizes the sum iteratively, at one bit per cycle, adjusts the exponent, detects overflow, underflow and zero, and packs an IEEE-754 single-precision word.
- Valid/ready handshakes are used on both sides.

Parameters:
- MANT_W, 25, width of incoming mantissa sum (carry bit + hidden bit + 23 fraction bits).
- EXP_W, 8, exponent width.
- SHCNT_W, 5, width of the shift-count output.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sum/exponent/sign valid.
- in_ready  out  1  block can accept a new operand.
- sign_in  in  1  result sign from the sign/compare logic.
- exp_in  in  8  tentative (larger, aligned) biased exponent.
- sum_in  in  25  mantissa sum; bit 24 is the adder carry-out.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts result.
- result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- overflow  out  1  exponent saturated; result is infinity.
- underflow  out  1  flushed to zero because normalization needed exponent < 1.
- zero  out  1  sum_in was exactly zero.
- norm_shift  out  5  number of left shifts performed (debug/verification).

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; in_ready=1 once reset deasserts.
  - out_valid, result, overflow, underflow, zero and norm_shift all go to 0.
  - Any in-flight operand is discarded.
- State machine: IDLE, SHIFT, DONE. in_ready = (state==IDLE). Acceptance occurs on an edge where in_valid && in_ready.
- On accept, the block latches sign, exp (in a 9-bit internal register), mant (25b) and clears the shift counter. Case priority is as follows:
  - sum_in==0: result={1'b0,31'b0}, zero=1, go to DONE.
  - sum_in[24]==1: mant>>=1 (LSB truncated), exp+=1. If the new exp ≥ 255: result={sign,8'hFF,23'b0}, overflow=1. Otherwise pack. Go to DONE.
  - exp_in==0: flush to {sign,31'b0}, underflow=1, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, evaluated each edge:
  - If mant[23]==1: pack {sign, exp[7:0], mant[22:0]}, go to DONE.
  - Else if exp==1: flush to {sign,31'b0}, underflow=1, go to DONE.
  - Else: mant<<=1, exp-=1, shift counter+=1.
- DONE: out_valid=1. result, flags and norm_shift are held stable while out_valid && !out_ready. A transfer occurs on an edge with out_ready=1; that edge clears out_valid and returns to IDLE. A new operand is accepted no earlier than the following edge (no bypass).
- Latency, counted in edges from the accept edge until out_valid is first high:
  - zero, carry or exp_in==0: 1 edge.
  - already normalized: 2 edges.
  - n leading zeros below bit 23: n+2 edges, with a maximum of 25.
- Flags are mutually exclusive and valid only while out_valid=1. They are cleared on handshake.
- Rounding is truncation only; rounding is out of scope.
- in_valid while busy is ignored; the upstream stage must hold its data.

Test Plan:
1. Already-normalized sum: sign=0, exp_in=8'h7F, sum_in=25'h0800000 -> result=32'h3F800000, flags 0, norm_shift=0, out_valid 2 edges after accept.
2. Carry-out: exp_in=8'h7F, sum_in=25'h1000000 -> result=32'h40000000, out_valid 1 edge after accept. Same sum with exp_in=8'hFE -> result=32'h7F800000, overflow=1.
3. Maximal normalization: exp_in=8'h7F, sum_in=25'h0000001 -> norm_shift=23, result=32'h34000000, out_valid 25 edges after accept.
4. Underflow: sign=1, exp_in=8'h05, sum_in=25'h0000100 -> result=32'h80000000, underflow=1, after 4 shifts (exp reaches 1).
5. Zero and back-pressure: sum_in=0, sign=1 -> result=32'h00000000, zero=1. Hold out_ready=0 for 5 cycles -> result, flags and out_valid stay stable; in_ready=0; in_valid pulses during this time are not accepted.
6. Reset mid-SHIFT: start case 3, assert rst after 10 cycles -> all outputs 0 immediately. After release, in_ready=1 and a subsequent case-1 operand yields 32'h3F800000.
